// File: rtl/glb_stream_pkg.sv
// glb_stream_pkg: token, sizing and state definitions shared by the GLB stream source and receive-side checker.
package glb_stream_pkg;
  localparam int DATA_W = 17;
  localparam int DEPTH = 2048;
  localparam int ADDR_W = 11;
  localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;
  typedef logic [DATA_W-1:0] token_t;
  typedef enum logic [2:0] {IDLE, FLUSH, ARM, STREAM, DONE} state_t;
endpackage

// File: rtl/glb_tx_skid.sv
// glb_tx_skid: 2-entry output FIFO whose head register drives the stream directly.
module glb_tx_skid
  import glb_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  token_t     push_data,
  input  logic       pop,
  output logic       full,
  output logic [1:0] count,
  output token_t     head_data,
  output logic       head_valid
);
  token_t e1;
  logic p, w;
  assign head_valid = count != 2'd0;
  assign full = count == 2'd2;
  assign p = pop && head_valid;
  assign w = push && (!full || p);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= 2'd0;
      head_data <= '0;
      e1 <= '0;
    end else if (clr) begin
      count <= 2'd0;
    end else begin
      if (p || (w && !head_valid)) head_data <= full ? e1 : push_data;
      if (w && (p ? full : count == 2'd1)) e1 <= push_data;
      count <= count + {1'b0, w} - {1'b0, p};
    end
endmodule

// File: rtl/glb_stream_tx.sv
// glb_stream_tx: streams a locally loaded token image onto a valid/ready fabric until TX_NUM done tokens are accepted.
module glb_stream_tx
  import glb_stream_pkg::*;
#(
  parameter int TX_NUM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  token_t            cfg_wr_data,
  input  logic [ADDR_W:0]   cfg_num_words,
  output token_t            data,
  output logic              valid,
  input  logic              ready,
  output logic              done,
  output logic              err_underrun,
  output logic              busy
);
  localparam int CNT_W = $clog2(TX_NUM + 1);
  state_t state;
  token_t mem [DEPTH];
  token_t rd_q;
  logic [ADDR_W:0] ptr, nw;
  logic [CNT_W-1:0] done_cnt;
  logic [1:0] count;
  logic full, rd_vld, rd_en, room, xfer, fin, under, push, we;
  assign nw = cfg_num_words > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : cfg_num_words;
  assign xfer = valid && ready;
  assign fin = state == STREAM && xfer && data == DONE_TOKEN && done_cnt == CNT_W'(TX_NUM - 1);
  // a read may issue when the slot freed by this cycle's transfer keeps occupancy within 2
  assign room = xfer || (!full && !(count[0] && rd_vld));
  assign rd_en = !flush && ptr < nw && room &&
                 (state == FLUSH || state == ARM || (state == STREAM && !fin));
  // underrun is flagged on the transfer that drains the last buffered word
  assign under = state == STREAM && !fin && ptr == nw && !rd_vld &&
                 (count == 2'd0 || (count == 2'd1 && xfer));
  assign push = rd_vld && !flush && !fin && (state == ARM || state == STREAM);
  assign we = cfg_wr_en && (state == IDLE || state == DONE);
  assign busy = state == ARM || state == STREAM;
  always_ff @(posedge clk)
    if (we) mem[cfg_wr_addr] <= cfg_wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_q <= '0;
    else if (rd_en) rd_q <= mem[ptr[ADDR_W-1:0]];
  glb_tx_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush || fin),
    .push       (push),
    .push_data  (rd_q),
    .pop        (xfer),
    .full       (full),
    .count      (count),
    .head_data  (data),
    .head_valid (valid)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rd_vld <= 1'b0;
      done_cnt <= '0;
      done <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      ptr <= flush ? '0 : ptr + (ADDR_W+1)'(rd_en);
      if (flush) begin
        state <= FLUSH;
        done_cnt <= '0;
        done <= 1'b0;
        err_underrun <= 1'b0;
      end else begin
        case (state)
          FLUSH: state <= ARM;
          ARM: begin
            state <= nw == '0 ? DONE : STREAM;
            done <= nw == '0;
            err_underrun <= nw == '0;
          end
          STREAM: begin
            if (xfer && data == DONE_TOKEN) done_cnt <= done_cnt + 1'b1;
            if (fin || under) begin
              state <= DONE;
              done <= 1'b1;
              err_underrun <= under;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_glb_stream_tx.sv
// tb_glb_stream_tx: directed vectors for glb_stream_tx with TX_NUM=1 and TX_NUM=2 instances sharing stimulus.
module tb_glb_stream_tx;
  import glb_stream_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, cfg_wr_en, ready;
  logic [ADDR_W-1:0] cfg_wr_addr;
  token_t cfg_wr_data;
  logic [ADDR_W:0] cfg_num_words;
  token_t data [2];
  logic valid [2];
  logic done [2];
  logic err [2];
  logic busy [2];
  int n_chk = 0, n_err = 0;
  token_t got_q[$];
  token_t img[$];
  token_t exp_q[$];
  int first_v, last_x, done_i;
  logic forbid_seen, err_at_done, valid_at_done;

  always #5 clk = ~clk;

  glb_stream_tx #(.TX_NUM(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_num_words(cfg_num_words), .data(data[0]), .valid(valid[0]),
    .ready(ready), .done(done[0]), .err_underrun(err[0]), .busy(busy[0])
  );
  glb_stream_tx #(.TX_NUM(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_num_words(cfg_num_words), .data(data[1]), .valid(valid[1]),
    .ready(ready), .done(done[1]), .err_underrun(err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_img();
    for (int i = 0; i < img.size(); i++) begin
      @(posedge clk); #1;
      cfg_wr_en = 1'b1;
      cfg_wr_addr = ADDR_W'(i);
      cfg_wr_data = img[i];
    end
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    cfg_num_words = (ADDR_W+1)'(img.size());
  endtask

  task automatic start();
    @(posedge clk); #1;
    flush = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // kind 1: async reset during transfer abort_at; kind 2: flush plus a dropped memory write
  task automatic collect(input int s, input int mode, input int abort_at, input int kind, input token_t forbid);
    logic pv, pr, v, r;
    token_t pd, d;
    got_q.delete();
    first_v = -1; last_x = -1; done_i = -1;
    forbid_seen = 1'b0; err_at_done = 1'b0; valid_at_done = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      ready = (mode == 0) || (i % 3 == 2);
      @(negedge clk);
      v = valid[s]; d = data[s]; r = ready;
      if (pv && !pr) begin
        check("hold_valid", 32'(v), 1);
        check("hold_data", 32'(d), 32'(pd));
      end
      if (v && first_v < 0) first_v = i;
      if (v && d == forbid) forbid_seen = 1'b1;
      if (done[s]) begin
        done_i = i;
        err_at_done = err[s];
        valid_at_done = v;
        break;
      end
      if (v && r && got_q.size() == abort_at) begin
        if (kind == 1) begin
          rst = 1'b1;
          #1;
          check("rst_valid", 32'(valid[s]), 0);
          check("rst_done", 32'(done[s]), 0);
          check("rst_busy", 32'(busy[s]), 0);
          @(posedge clk); #1;
          rst = 1'b0;
        end else begin
          flush = 1'b1;
          cfg_wr_en = 1'b1;
          cfg_wr_addr = '0;
          cfg_wr_data = 17'h01234;
          @(posedge clk); #1;
          cfg_wr_en = 1'b0;
          @(negedge clk);
          check("flush_valid", 32'(valid[s]), 0);
          check("flush_busy", 32'(busy[s]), 0);
        end
        return;
      end
      if (v && r) begin
        got_q.push_back(d);
        last_x = i;
      end
      pv = v; pr = r; pd = d;
    end
    check("done_seen", 32'(done_i >= 0), 1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, i < got_q.size() ? 32'(got_q[i]) : 32'hdead, 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_num_words = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(data[0]), 0);
    check("rst_valid0", 32'(valid[0]), 0);
    check("rst_done0", 32'(done[0]), 0);
    check("rst_err0", 32'(err[0]), 0);
    check("rst_busy0", 32'(busy[0]), 0);
    rst = 1'b0;

    img = '{17'd5, 17'd6, 17'd7, DONE_TOKEN};
    write_img();
    start();
    collect(0, 0, -1, 0, 17'h1ffff);
    exp_q = '{17'd5, 17'd6, 17'd7, DONE_TOKEN};
    check_seq("t1_seq");
    check("t1_first_valid", 32'(first_v), 1);
    check("t1_last_xfer", 32'(last_x), 4);
    check("t1_done_cycle", 32'(done_i), 5);
    check("t1_err", 32'(err_at_done), 0);
    check("t1_valid_at_done", 32'(valid_at_done), 0);

    start();
    collect(0, 1, -1, 0, 17'h1ffff);
    check_seq("t2_seq");
    check("t2_done_cycle", 32'(done_i), 32'(last_x + 1));
    check("t2_err", 32'(err_at_done), 0);

    img = '{17'd1, DONE_TOKEN, 17'd2, DONE_TOKEN, 17'd3};
    write_img();
    start();
    collect(1, 0, -1, 0, 17'd3);
    exp_q = '{17'd1, DONE_TOKEN, 17'd2, DONE_TOKEN};
    check_seq("t3_seq");
    check("t3_tok3_seen", 32'(forbid_seen), 0);
    check("t3_done_cycle", 32'(done_i), 32'(last_x + 1));
    check("t3_err", 32'(err_at_done), 0);

    img = '{17'd1, 17'd2, 17'd3};
    write_img();
    start();
    collect(0, 0, -1, 0, 17'h1ffff);
    exp_q = '{17'd1, 17'd2, 17'd3};
    check_seq("t4_seq");
    check("t4_err", 32'(err_at_done), 1);
    check("t4_done_cycle", 32'(done_i), 32'(last_x + 1));
    cfg_num_words = '0;
    start();
    collect(0, 0, -1, 0, 17'h1ffff);
    check("t4_empty_len", 32'(got_q.size()), 0);
    check("t4_empty_done_cycle", 32'(done_i), 1);
    check("t4_empty_err", 32'(err_at_done), 1);

    img = '{17'd100, 17'd101, 17'd102, 17'd103, 17'd104, 17'd105, 17'd106, 17'd107, 17'd108, DONE_TOKEN};
    write_img();
    start();
    collect(0, 0, 2, 1, 17'h1ffff);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_idle_busy", 32'(busy[0]), 0);
    check("t5_idle_valid", 32'(valid[0]), 0);
    start();
    collect(0, 0, -1, 0, 17'h1ffff);
    exp_q = img;
    check_seq("t5_seq");
    check("t5_err", 32'(err_at_done), 0);

    img = '{17'd5, 17'd6, 17'd7, DONE_TOKEN};
    write_img();
    start();
    collect(0, 0, 2, 2, 17'h1ffff);
    start();
    collect(0, 0, -1, 0, 17'h1ffff);
    exp_q = '{17'd5, 17'd6, 17'd7, DONE_TOKEN};
    check_seq("t6_seq");
    check("t6_first_valid", 32'(first_v), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/glb_stream_tx.md
Name: glb_stream_tx

Overview:
Synthesizable GLB-side stream source; the transmit counterpart of the GLB read sink. It holds a locally loaded token image, which is written through a config port. After flush is released, it streams the image onto a 17-bit valid/ready fabric interface. It finishes once TX_NUM done tokens (17'h10100) have been accepted downstream. It drives the input edge of sparse unit tests and the tile input path.

Parameters:
DATA_W, 17, token width; bit 16 marks a control token.
DEPTH, 2048, words of local token memory.
ADDR_W, 11, log2(DEPTH).
TX_NUM, 1, number of done tokens that end the stream.
DONE_TOKEN, 17'h10100, done-token encoding.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  high: clear stream state; falling edge arms streaming
cfg_wr_en  in  1  memory write strobe (honoured only in IDLE/DONE)
cfg_wr_addr  in  ADDR_W  memory write address
cfg_wr_data  in  DATA_W  memory write data
cfg_num_words  in  ADDR_W+1  image length in words, 0..DEPTH
data  out  DATA_W  stream token
valid  out  1  token valid
ready  in  1  downstream accept
done  out  1  sticky completion flag
err_underrun  out  1  sticky: image exhausted before TX_NUM done tokens sent
busy  out  1  high in ARM/STREAM

Behaviour:
- Reset values: data=0, valid=0, done=0, err_underrun=0, busy=0, state=IDLE, all pointers/counters 0. Memory contents are not reset.
- Transfer: occurs on a cycle where valid&&ready at posedge clk.
- Valid stability: once valid is high, valid and data hold stable until transfer.
- Valid timing: valid never depends combinationally on ready.
- Memory: synchronous-read, 1-cycle latency. Read address rd_ptr (ADDR_W+1 bits) advances on each issued read.
- Output buffer: 2-entry skid FIFO (glb_tx_skid).
  - A read is issued when rd_ptr < cfg_num_words and (FIFO entries + reads in flight) < 2.
  - With ready held high, sustained throughput is 1 token/cycle.
- States:
  - IDLE: flush rising -> FLUSH.
  - FLUSH: pointers, FIFO, sent_cnt and done_cnt clear; done/err clear. flush falling -> ARM.
  - ARM: one cycle; issue read of addr 0 if cfg_num_words>0, else set err_underrun and go to DONE. -> STREAM.
  - STREAM: issue reads and present tokens.
    - On transfer of a token == DONE_TOKEN, done_cnt++.
    - On transfer that makes done_cnt==TX_NUM: stop issuing reads, discard the remaining FIFO/in-flight data, and the next state is DONE. First valid appears 2 cycles after flush falls.
    - If rd_ptr==cfg_num_words, FIFO is empty, nothing is in flight, and done_cnt<TX_NUM: set err_underrun, -> DONE.
  - DONE: valid=0, done=1. A flush rising edge -> FLUSH (re-run without reset).
- Flush asserted in any state: synchronously -> FLUSH and valid drops the next cycle. A token being transferred that same cycle counts as sent.
- Simultaneous: a cfg_wr_en to the address being read in the same cycle returns old data (read-first). cfg_wr_en outside IDLE/DONE is dropped.
- done asserts the cycle after the final done-token transfer. valid is 0 from that cycle on.
- Async rst mid-stream: outputs go to reset values immediately. Subsequent flush required to restart.
- cfg_num_words > DEPTH: clamp to DEPTH.

Decomposition:
- Package glb_stream_pkg: DATA_W, DONE_TOKEN, token typedef (logic [16:0]), state enum {IDLE, FLUSH, ARM, STREAM, DONE}. The package is shared with the receive-side checker.
- Sub-module glb_tx_skid: 2-entry FIFO.
  - Ports: push, push_data, pop, full, count, head_data, head_valid.
  - Supports simultaneous push/pop when full.

Test Plan:
1. Load [5,6,7,10100h], num_words=4, TX_NUM=1, ready=1 -> first valid 2 cycles after flush falls; 4 back-to-back transfers 5,6,7,10100h; done=1 next cycle; err_underrun=0.
2. Same image, ready pattern 0,0,1 repeating -> identical sequence; data stable while ready=0; no duplicates or drops; done after 4th transfer.
3. Image [1,10100h,2,10100h,3], TX_NUM=2 -> 4 transfers; token 3 never valid; done=1.
4. Image [1,2,3], TX_NUM=1 -> 3 transfers; err_underrun=1 and done=1 one cycle after the last transfer; cfg_num_words=0 -> err_underrun immediately after ARM.
5. Assert rst during 3rd transfer of a 10-word image -> valid=0, done=0 asynchronously. Flush pulse -> stream restarts from addr 0 with unchanged memory contents.
6. Flush during STREAM after 2 transfers -> valid low next cycle; on flush fall, stream restarts from word 0. cfg_wr_en during STREAM leaves memory unchanged (verify via rerun).
